// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port main-memory arbiter.
// State/op encodings and default bus widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_RISC_DATA = 32;
    localparam int DEF_MAIN_DATA = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY0   = 2'b01,
        BUSY1   = 2'b10,
        RELEASE = 2'b11
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    function automatic op_t op_of(input logic re, input logic we);
        return we ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin pick with a favoured-port pointer.
// Pointer moves to the loser of each accepted grant.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            (req == 2'b11): gnt = ptr ? 2'b10 : 2'b01;
            (req == 2'b01): gnt = 2'b01;
            (req == 2'b10): gnt = 2'b10;
            default:        gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            ptr <= 1'b0;
        end else if (en && gnt != 2'b00) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache (port 0) and D-cache (port 1),
// with round-robin grant, latched access and a busy-state watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RISC_data = DEF_RISC_DATA,
    parameter int main_data = DEF_MAIN_DATA,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 p0_RE,
    input  logic                 p0_WE,
    input  logic [ADDR_W-1:0]    p0_A,
    input  logic [RISC_data-1:0] p0_WD,
    output logic                 p0_done,
    input  logic                 p1_RE,
    input  logic                 p1_WE,
    input  logic [ADDR_W-1:0]    p1_A,
    input  logic [RISC_data-1:0] p1_WD,
    output logic                 p1_done,
    output logic [main_data-1:0] rd_data,
    output logic                 mem_RE,
    output logic                 mem_WE,
    output logic [ADDR_W-1:0]    mem_A,
    output logic [RISC_data-1:0] mem_WD,
    input  logic [main_data-1:0] mem_RD,
    input  logic                 mem_done,
    output logic                 err
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t               state_q;
    state_t               state_d;
    op_t                  op_q;
    logic [ADDR_W-1:0]    a_q;
    logic [RISC_data-1:0] wd_q;
    logic [WD_W-1:0]      wdog_q;
    logic [1:0]           req;
    logic [1:0]           gnt;
    logic                 grant;
    logic                 busy;

    assign req   = {p1_RE | p1_WE, p0_RE | p0_WE};
    assign grant = (state_q == IDLE) && (req != 2'b00);
    assign busy  = (state_q == BUSY0) || (state_q == BUSY1);

    rr_arbiter2 u_rr (
        .clk (clk),
        .RST (RST),
        .req (req),
        .en  (grant),
        .gnt (gnt)
    );

    always_comb begin
        state_d = state_q;
        p0_done = 1'b0;
        p1_done = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt[0]) begin
                    state_d = BUSY0;
                end else if (gnt[1]) begin
                    state_d = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                // completion on the expiry cycle still wins over abort
                if (mem_done) begin
                    p0_done = (state_q == BUSY0);
                    p1_done = (state_q == BUSY1);
                    state_d = RELEASE;
                end else if (wdog_q == WD_LAST) begin
                    err     = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            a_q     <= '0;
            wd_q    <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                a_q    <= gnt[1] ? p1_A : p0_A;
                wd_q   <= gnt[1] ? p1_WD : p0_WD;
                op_q   <= gnt[1] ? op_of(p1_RE, p1_WE) : op_of(p0_RE, p0_WE);
                wdog_q <= '0;
            end else if (busy && wdog_q != WD_LAST) begin
                wdog_q <= wdog_q + WD_W'(1);
            end
        end
    end

    assign mem_RE  = busy && (op_q == OP_READ);
    assign mem_WE  = busy && (op_q == OP_WRITE);
    assign mem_A   = a_q;
    assign mem_WD  = wd_q;
    assign rd_data = mem_RD;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a
// transaction-level timing model.
module tb_mem_port_arbiter;

    localparam int T = 8;

    logic         clk = 1'b0;
    logic         RST;
    logic         p0_RE, p0_WE, p1_RE, p1_WE;
    logic [7:0]   p0_A, p1_A;
    logic [31:0]  p0_WD, p1_WD;
    logic         p0_done, p1_done;
    logic [127:0] rd_data;
    logic         mem_RE, mem_WE;
    logic [7:0]   mem_A;
    logic [31:0]  mem_WD;
    logic [127:0] mem_RD;
    logic         mem_done;
    logic         err;

    mem_port_arbiter #(
        .ADDR_W    (8),
        .RISC_data (32),
        .main_data (128),
        .TIMEOUT   (T)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .p0_RE    (p0_RE),
        .p0_WE    (p0_WE),
        .p0_A     (p0_A),
        .p0_WD    (p0_WD),
        .p0_done  (p0_done),
        .p1_RE    (p1_RE),
        .p1_WE    (p1_WE),
        .p1_A     (p1_A),
        .p1_WD    (p1_WD),
        .p1_done  (p1_done),
        .rd_data  (rd_data),
        .mem_RE   (mem_RE),
        .mem_WE   (mem_WE),
        .mem_A    (mem_A),
        .mem_WD   (mem_WD),
        .mem_RD   (mem_RD),
        .mem_done (mem_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           port;
        logic [7:0]   a;
        logic [31:0]  wd;
        bit           wr;
        int           k;
        bit           to;
        logic [127:0] rd;
        int           t;
    } exp_t;

    exp_t sb[$];
    bit   mon_en   = 1'b0;
    bit   mon_have = 1'b0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor: pops the expected access at strobe start, checks completion.
    initial begin : monitor
        exp_t cur;
        int   cnt;
        bit   prev_s;
        bit   s;
        cnt    = 0;
        prev_s = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                mon_have = 1'b0;
                prev_s   = 1'b0;
            end else begin
                s = mem_RE | mem_WE;
                if (s && !prev_s) begin
                    if (mon_have || sb.size() == 0) begin
                        flag("stray_grant");
                    end else begin
                        cur      = sb.pop_front();
                        mon_have = 1'b1;
                        cnt      = 0;
                        chk("grant_cycle", 128'(cyc), 128'(cur.t));
                        chk("op_we", 128'(mem_WE), 128'(cur.wr));
                        chk("op_re", 128'(mem_RE), 128'(!cur.wr));
                        chk("mem_WD", 128'(mem_WD), 128'(cur.wd));
                    end
                end
                if (s && mon_have) begin
                    cnt++;
                    chk("mem_A", 128'(mem_A), 128'(cur.a));
                end
                if (p0_done || p1_done || err) begin
                    if (!mon_have) begin
                        flag("stray_done");
                    end else begin
                        chk("strobe_len", 128'(cnt), 128'(cur.k));
                        chk("err", 128'(err), 128'(cur.to));
                        chk("p0_done", 128'(p0_done),
                            128'(!cur.to && cur.port == 0));
                        chk("p1_done", 128'(p1_done),
                            128'(!cur.to && cur.port == 1));
                        if (!cur.to) chk("rd_data", rd_data, cur.rd);
                        mon_have = 1'b0;
                    end
                end else if (!s && prev_s && mon_have) begin
                    flag("no_completion");
                    mon_have = 1'b0;
                end
                prev_s = s;
            end
        end
    end

    initial begin : stim
        bit           act [2];
        bit           re [2];
        bit           we [2];
        logic [7:0]   a [2];
        logic [31:0]  wd [2];
        int           gap [2];
        int           c, t, e, ptr, w, cur_port, L, k, r, op;
        bit           to_cur, issuing, in_str, md;
        logic [127:0] rd_cur;

        RST = 1'b0;
        p0_RE = 1'b1; p0_WE = 1'b0; p0_A = 8'h5A; p0_WD = 32'h1234;
        p1_RE = 1'b0; p1_WE = 1'b0; p1_A = 8'h00; p1_WD = 32'h0;
        mem_RD = '0;
        mem_done = 1'b0;

        // Reset held two edges with a pending request
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_RE", 128'(mem_RE), 0);
        chk("rst_mem_WE", 128'(mem_WE), 0);
        chk("rst_mem_A", 128'(mem_A), 0);
        chk("rst_mem_WD", 128'(mem_WD), 0);
        chk("rst_err", 128'(err), 0);
        chk("rst_p0_done", 128'(p0_done), 0);
        chk("rst_p1_done", 128'(p1_done), 0);
        RST = 1'b1;
        @(negedge clk);
        chk("first_grant_RE", 128'(mem_RE), 1);
        chk("first_grant_WE", 128'(mem_WE), 0);
        chk("first_grant_A", 128'(mem_A), 128'(8'h5A));
        RST = 1'b0;
        p0_RE = 1'b0;
        @(negedge clk);
        chk("rst_abort_RE", 128'(mem_RE), 0);
        RST = 1'b1;
        mon_en = 1'b1;

        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; re[p] = 1'b0; we[p] = 1'b0;
            a[p] = '0; wd[p] = '0; gap[p] = 0;
        end
        t = -100; e = -100; ptr = 0; cur_port = 0;
        to_cur = 1'b0; rd_cur = '0;

        for (int n = 0; n < 1620; n++) begin
            @(posedge clk);
            #1;
            c = cyc;
            issuing = (n < 1500);
            if (c == e + 1) begin
                act[cur_port] = 1'b0;
                gap[cur_port] = $urandom_range(0, 3);
            end
            in_str = (c >= t) && (c <= e);
            for (int p = 0; p < 2; p++) begin
                if (!act[p]) begin
                    if (gap[p] > 0) begin
                        gap[p]--;
                    end else if (issuing && $urandom_range(0, 2) == 0) begin
                        op     = $urandom_range(0, 3);
                        act[p] = 1'b1;
                        re[p]  = (op != 2);
                        we[p]  = (op >= 2);
                        a[p]   = 8'($urandom);
                        wd[p]  = $urandom;
                    end
                end else if (in_str && p == cur_port
                             && $urandom_range(0, 2) == 0) begin
                    a[p]  = 8'($urandom);
                    wd[p] = $urandom;
                end
            end
            // Arbiter free again two cycles after the completing cycle
            if (c >= e + 2 && (act[0] || act[1])) begin
                w   = (act[0] && act[1]) ? ptr : (act[0] ? 0 : 1);
                ptr = 1 - w;
                r   = $urandom_range(0, 9);
                L   = (r < 6) ? $urandom_range(1, 4) :
                      (r == 6) ? T - 1 : (r == 7) ? T :
                      (r == 8) ? T + 1 : T + 4;
                k        = (L < T) ? L : T;
                to_cur   = (L > T);
                t        = c + 1;
                e        = t + k - 1;
                cur_port = w;
                rd_cur   = {$urandom, $urandom, $urandom, $urandom};
                sb.push_back('{port: w, a: a[w], wd: wd[w], wr: we[w],
                               k: k, to: to_cur, rd: rd_cur, t: t});
            end
            in_str = (c >= t) && (c <= e);
            md = ((c == e) && !to_cur)
                 || (!in_str && $urandom_range(0, 5) == 0);
            mem_done = md;
            mem_RD   = (c == e) ? rd_cur
                       : {$urandom, $urandom, $urandom, $urandom};
            p0_RE = re[0] & act[0]; p0_WE = we[0] & act[0];
            p0_A  = a[0];           p0_WD = wd[0];
            p1_RE = re[1] & act[1]; p1_WE = we[1] & act[1];
            p1_A  = a[1];           p1_WD = wd[1];
        end
        chk("drain_queue", 128'(sb.size()), 0);
        chk("drain_open", 128'(mon_have), 0);
        mon_en = 1'b0;

        // Reset in the middle of a port-1 access
        p0_RE = 1'b0; p0_WE = 1'b0;
        p1_RE = 1'b1; p1_WE = 1'b0; p1_A = 8'h3C;
        mem_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("busy1_RE", 128'(mem_RE), 1);
        chk("busy1_A", 128'(mem_A), 128'(8'h3C));
        RST = 1'b0;
        @(posedge clk);
        #1;
        mem_done = 1'b1;
        @(negedge clk);
        chk("midrst_RE", 128'(mem_RE), 0);
        chk("midrst_WE", 128'(mem_WE), 0);
        chk("late_done_p1", 128'(p1_done), 0);
        chk("late_done_err", 128'(err), 0);
        RST = 1'b1;
        mem_done = 1'b0;
        p0_RE = 1'b1; p0_A = 8'h77;
        @(negedge clk);
        chk("post_rst_grant_A", 128'(mem_A), 128'(8'h77));
        chk("post_rst_grant_RE", 128'(mem_RE), 1);
        chk("post_rst_p1_done", 128'(p1_done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
